// File: rtl/bpu_pkg.sv
// Shared types and constants for the branch resolution path downstream of the pshare predictor.
package bpu_pkg;
  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned INSN_BYTES = 4;

  typedef enum logic {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } state_t;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] pc;
    logic                  taken;
    logic [DEF_ADDR_W-1:0] target;
  } entry_t;
endpackage

// File: rtl/bru_fifo.sv
// In-order buffer of in-flight predictions; flush empties it and overrides any same-cycle push/pop.
module bru_fifo
  import bpu_pkg::*;
#(
  parameter int unsigned W     = 65,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  always_comb begin
    empty   = (wr_ptr == rd_ptr);
    full    = (wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]});
    count   = wr_ptr - rd_ptr;
    dout    = mem[rd_ptr[AW-1:0]];
    do_push = push && !full && !flush;
    do_pop  = pop && !empty && !flush;
  end

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/branch_resolve_unit.sv
// Pairs buffered predictions with resolved outcomes, redirects on mispredict, models recovery
// penalty and keeps saturating accuracy/stall statistics.
module branch_resolve_unit
  import bpu_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned PENALTY = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pred_valid,
  output logic                   pred_ready,
  input  logic [ADDR_W-1:0]      pred_pc,
  input  logic                   pred_taken,
  input  logic [ADDR_W-1:0]      pred_target,
  input  logic                   res_valid,
  output logic                   res_ready,
  input  logic                   res_taken,
  input  logic [ADDR_W-1:0]      res_target,
  output logic                   redirect_valid,
  output logic [ADDR_W-1:0]      redirect_pc,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic [CNT_W-1:0]       total_branch,
  output logic [CNT_W-1:0]       total_mispred,
  output logic [CNT_W-1:0]       stall_cycles,
  output logic                   orphan_err
);
  localparam int unsigned PW = $clog2(PENALTY + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic              taken;
    logic [ADDR_W-1:0] target;
  } slot_t;

  state_t          state;
  state_t          state_nxt;
  logic [PW-1:0]   pen_cnt;
  slot_t           head;
  slot_t           push_slot;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic            resolve;
  logic            mispred;

  always_comb begin
    push_slot = '{pc: pred_pc, taken: pred_taken, target: pred_target};
    push      = pred_valid && pred_ready;
    resolve   = res_valid && res_ready;
    mispred   = resolve && ((head.taken != res_taken) ||
                            (head.taken && (head.target != res_target)));
    pop       = resolve && !mispred;
  end

  // Flush has priority inside the FIFO, so a push racing a mispredict is dropped there.
  bru_fifo #(
    .W     ($bits(slot_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (mispred),
    .din   (push_slot),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (occupancy)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN:     if (mispred) state_nxt = RECOVER;
      RECOVER: if (pen_cnt == PW'(1)) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    pred_ready = reset && (state == RUN) && !full;
    res_ready  = reset && !empty;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pen_cnt        <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      total_branch   <= '0;
      total_mispred  <= '0;
      stall_cycles   <= '0;
      orphan_err     <= 1'b0;
    end else begin
      redirect_valid <= mispred;
      if (mispred) begin
        redirect_pc <= res_taken ? res_target : head.pc + ADDR_W'(INSN_BYTES);
        pen_cnt     <= PW'(PENALTY);
      end else if (state == RECOVER) begin
        pen_cnt <= pen_cnt - PW'(1);
      end
      if (resolve && (total_branch != '1))  total_branch  <= total_branch + CNT_W'(1);
      if (mispred && (total_mispred != '1)) total_mispred <= total_mispred + CNT_W'(1);
      if ((state == RECOVER) && (stall_cycles != '1)) stall_cycles <= stall_cycles + CNT_W'(1);
      if (res_valid && empty) orphan_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench: table-driven push/resolve vectors plus hand sequences, with a redirect scoreboard.
module tb_branch_resolve_unit;
  import bpu_pkg::*;

  localparam int unsigned AW    = 32;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = 32;
  localparam int unsigned PEN   = 3;

  logic                   clk = 1'b0;
  logic                   reset = 1'b0;
  logic                   pred_valid = 1'b0;
  logic                   pred_ready;
  logic [AW-1:0]          pred_pc = '0;
  logic                   pred_taken = 1'b0;
  logic [AW-1:0]          pred_target = '0;
  logic                   res_valid = 1'b0;
  logic                   res_ready;
  logic                   res_taken = 1'b0;
  logic [AW-1:0]          res_target = '0;
  logic                   redirect_valid;
  logic [AW-1:0]          redirect_pc;
  logic [$clog2(DEPTH):0] occupancy;
  logic [CW-1:0]          total_branch;
  logic [CW-1:0]          total_mispred;
  logic [CW-1:0]          stall_cycles;
  logic                   orphan_err;

  always #5 clk = ~clk;

  branch_resolve_unit #(
    .ADDR_W  (AW),
    .DEPTH   (DEPTH),
    .CNT_W   (CW),
    .PENALTY (PEN)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .pred_valid     (pred_valid),
    .pred_ready     (pred_ready),
    .pred_pc        (pred_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_taken      (res_taken),
    .res_target     (res_target),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .occupancy      (occupancy),
    .total_branch   (total_branch),
    .total_mispred  (total_mispred),
    .stall_cycles   (stall_cycles),
    .orphan_err     (orphan_err)
  );

  typedef struct {
    entry_t        pred;
    logic          r_taken;
    logic [AW-1:0] r_target;
    logic          exp_mis;
    logic [AW-1:0] exp_pc;
  } vec_t;

  typedef struct packed {
    logic          mis;
    logic [AW-1:0] pc;
  } redir_t;

  vec_t    vecs [6];
  redir_t  sb [$];
  logic    acc_q = 1'b0;
  int      n_checks = 0;
  int      n_fail = 0;
  logic [CW-1:0] e_br = '0;
  logic [CW-1:0] e_mis = '0;
  logic [CW-1:0] e_stall = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Outputs are compared at the falling edge; the acceptance seen here is what the next rising edge commits.
  always @(negedge clk) begin
    if (acc_q) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_underflow: actual resolve with no expectation queued at %0t", $time);
      end else begin
        redir_t e;
        e = sb.pop_front();
        check("redirect_valid", redirect_valid, e.mis);
        if (e.mis) check("redirect_pc", redirect_pc, e.pc);
      end
    end else begin
      check("redirect_idle", redirect_valid, 1'b0);
    end
    acc_q = reset && res_valid && res_ready;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int i, input logic [AW-1:0] pc, input logic t, input logic [AW-1:0] tgt,
                         input logic rt, input logic [AW-1:0] rtgt, input logic mis, input logic [AW-1:0] rpc);
    vecs[i].pred.pc     = pc;
    vecs[i].pred.taken  = t;
    vecs[i].pred.target = tgt;
    vecs[i].r_taken     = rt;
    vecs[i].r_target    = rtgt;
    vecs[i].exp_mis     = mis;
    vecs[i].exp_pc      = rpc;
  endtask

  task automatic push(input logic [AW-1:0] pc, input logic t, input logic [AW-1:0] tgt);
    pred_valid  = 1'b1;
    pred_pc     = pc;
    pred_taken  = t;
    pred_target = tgt;
    check("pred_ready_push", pred_ready, 1'b1);
    tick();
    pred_valid = 1'b0;
  endtask

  task automatic expect_resolve(input logic mis, input logic [AW-1:0] rpc);
    sb.push_back('{mis: mis, pc: rpc});
    e_br = e_br + 1;
    if (mis) e_mis = e_mis + 1;
  endtask

  task automatic resolve(input logic t, input logic [AW-1:0] tgt, input logic mis, input logic [AW-1:0] rpc);
    res_valid  = 1'b1;
    res_taken  = t;
    res_target = tgt;
    check("res_ready", res_ready, 1'b1);
    expect_resolve(mis, rpc);
    tick();
    res_valid = 1'b0;
  endtask

  task automatic recover();
    for (int k = 0; k < int'(PEN); k++) begin
      check("pred_ready_recover", pred_ready, 1'b0);
      tick();
    end
    check("pred_ready_after_recover", pred_ready, 1'b1);
    e_stall = e_stall + PEN;
  endtask

  task automatic check_stats();
    check("total_branch", total_branch, e_br);
    check("total_mispred", total_mispred, e_mis);
    check("stall_cycles", stall_cycles, e_stall);
  endtask

  initial begin
    set_vec(0, 32'h100, 1'b1, 32'h200, 1'b1, 32'h200, 1'b0, 32'h0);
    set_vec(1, 32'h104, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0);
    set_vec(2, 32'h108, 1'b1, 32'h400, 1'b1, 32'h400, 1'b0, 32'h0);
    set_vec(3, 32'h300, 1'b1, 32'h500, 1'b1, 32'h504, 1'b1, 32'h504);
    set_vec(4, 32'h10,  1'b1, 32'h90,  1'b0, 32'h0,   1'b1, 32'h14);
    set_vec(5, 32'hFFFF_FFFC, 1'b1, 32'h8, 1'b0, 32'h0, 1'b1, 32'h0);

    // Reset state
    tick();
    tick();
    check("pred_ready_in_reset", pred_ready, 1'b0);
    check("res_ready_in_reset", res_ready, 1'b0);
    reset = 1'b1;
    #1;
    check("occupancy_reset", occupancy, 0);
    check("orphan_reset", orphan_err, 1'b0);
    check("redirect_pc_reset", redirect_pc, 0);
    check("pred_ready_reset", pred_ready, 1'b1);
    check_stats();

    // Table: one prediction in flight per vector
    for (int i = 0; i < 6; i++) begin
      push(vecs[i].pred.pc, vecs[i].pred.taken, vecs[i].pred.target);
      check("occ_one", occupancy, 1);
      resolve(vecs[i].r_taken, vecs[i].r_target, vecs[i].exp_mis, vecs[i].exp_pc);
      check("occ_zero", occupancy, 0);
      if (vecs[i].exp_mis) recover();
      check_stats();
    end

    // Three in flight, back-to-back correct resolves
    push(32'h100, 1'b1, 32'h200);
    push(32'h104, 1'b0, 32'h0);
    push(32'h108, 1'b1, 32'h400);
    check("occ_three", occupancy, 3);
    resolve(1'b1, 32'h200, 1'b0, 32'h0);
    resolve(1'b0, 32'h0,   1'b0, 32'h0);
    resolve(1'b1, 32'h400, 1'b0, 32'h0);
    check("occ_drained", occupancy, 0);
    check_stats();

    // Mispredict on head flushes younger wrong-path entries
    push(32'h40, 1'b0, 32'h0);
    push(32'h44, 1'b1, 32'h10);
    push(32'h48, 1'b0, 32'h0);
    resolve(1'b1, 32'h80, 1'b1, 32'h80);
    check("occ_flushed", occupancy, 0);
    recover();
    check_stats();

    // Full FIFO: pop with pending push refuses the push; then mispredict drops a racing push
    for (int i = 0; i < int'(DEPTH); i++) push(32'h1000 + AW'(4 * i), i[0], 32'h2000 + AW'(i));
    check("occ_full", occupancy, DEPTH);
    check("pred_ready_full", pred_ready, 1'b0);
    pred_valid  = 1'b1;
    pred_pc     = 32'h5000;
    pred_taken  = 1'b0;
    pred_target = 32'h0;
    res_valid   = 1'b1;
    res_taken   = 1'b0;
    res_target  = 32'h0;
    check("pred_ready_full_pop", pred_ready, 1'b0);
    check("res_ready_full", res_ready, 1'b1);
    expect_resolve(1'b0, 32'h0);
    tick();
    check("occ_after_refused_push", occupancy, DEPTH - 1);
    check("pred_ready_not_full", pred_ready, 1'b1);
    res_taken = 1'b0;
    expect_resolve(1'b1, 32'h1008);
    tick();
    pred_valid = 1'b0;
    res_valid  = 1'b0;
    check("occ_flush_with_push", occupancy, 0);
    recover();
    check_stats();

    // Outcome with nothing in flight
    res_valid  = 1'b1;
    res_taken  = 1'b1;
    res_target = 32'h123;
    check("res_ready_empty", res_ready, 1'b0);
    tick();
    res_valid = 1'b0;
    check("orphan_set", orphan_err, 1'b1);
    tick();
    tick();
    check("orphan_sticky", orphan_err, 1'b1);
    check_stats();

    // Reset with five entries held
    for (int i = 0; i < 5; i++) push(32'h7000 + AW'(4 * i), 1'b0, 32'h0);
    check("occ_five", occupancy, 5);
    reset = 1'b0;
    tick();
    e_br = '0;
    e_mis = '0;
    e_stall = '0;
    check("occ_after_reset", occupancy, 0);
    check("orphan_after_reset", orphan_err, 1'b0);
    check("pred_ready_held_reset", pred_ready, 1'b0);
    check_stats();
    reset = 1'b1;
    #1;
    check("pred_ready_after_reset", pred_ready, 1'b1);
    check("res_ready_after_reset", res_ready, 1'b0);
    tick();
    tick();

    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Downstream consumer of the pshare predictor. Buffers in-flight predictions (prediction, predicted target) in order and pairs each with its architectural outcome when it resolves. Detects mispredictions, emits a redirect PC, flushes wrong-path entries and models a fixed recovery penalty. Keeps accuracy and stall statistics for the predictor experiments.

## Interface
Parameters:
- ADDR_W, 32, address width
- DEPTH, 8, in-flight entries; power of two, ≥2
- CNT_W, 32, statistics counter width
- PENALTY, 3, recovery cycles after a mispredict; ≥1

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low
- pred_valid  in  1  prediction offered
- pred_ready  out  1  prediction accepted this cycle if valid
- pred_pc  in  ADDR_W  branch address
- pred_taken  in  1  predicted direction
- pred_target  in  ADDR_W  predicted target (meaningful when pred_taken)
- res_valid  in  1  outcome offered for oldest branch
- res_ready  out  1  outcome accepted this cycle if valid
- res_taken  in  1  actual direction
- res_target  in  ADDR_W  actual target (meaningful when res_taken)
- redirect_valid  out  1  one-cycle mispredict pulse
- redirect_pc  out  ADDR_W  correct next fetch address
- occupancy  out  log2(DEPTH)+1  entries held
- total_branch  out  CNT_W  resolved branches
- total_mispred  out  CNT_W  mispredicted branches
- stall_cycles  out  CNT_W  cycles spent in RECOVER
- orphan_err  out  1  sticky: outcome arrived with FIFO empty

## Operation
- FSM: RUN, RECOVER. Reset → RUN.
- pred_ready = reset && state==RUN && !full. Push on pred_valid && pred_ready.
- res_ready = reset && !empty. Resolve on res_valid && res_ready, compared against head entry.
- Mispredict if pred_taken≠res_taken, or both taken and pred_target≠res_target.
- redirect_pc = res_taken ? res_target : head_pc + 4 (modulo 2^ADDR_W).
- Correct resolve: pop head; total_branch+1.
- Mispredict resolve: entire FIFO cleared (head and all younger wrong-path entries); any push in the same cycle discarded; total_branch+1, total_mispred+1; state → RECOVER.
- RECOVER: pred_ready=0; down-counter loaded with PENALTY; stall_cycles+1 each RECOVER cycle; counter reaching terminal count → RUN.
- Push and correct pop in same cycle: both take effect, occupancy unchanged. When full, push refused even if pop occurs (pred_ready depends only on registered state).
- res_valid while empty (including during RECOVER): not accepted, orphan_err ← 1, counters unchanged. orphan_err cleared only by reset.
- All counters saturate at all-ones; no wrap.
- Pointers wrap modulo DEPTH; full/empty from extra pointer bit.

## Timing
- Reset (edge with reset low): state RUN, FIFO empty, occupancy 0, all counters 0, orphan_err 0, redirect_valid 0, redirect_pc 0. pred_ready/res_ready are 0 while reset is low. A reset mid-RECOVER or mid-stream aborts everything on that edge.
- Resolve at edge t: redirect_valid, redirect_pc, counters and occupancy updated after edge t (visible cycle t+1). redirect_valid high exactly one cycle.
- Mispredict at edge t: RECOVER during cycles t+1…t+PENALTY; pred_ready returns high in cycle t+PENALTY+1; stall_cycles increased by exactly PENALTY.
- Push at edge t: entry resolvable from cycle t+1 (no same-cycle bypass into empty FIFO).
- Back-to-back correct resolves: one per cycle.

## Structure
- Package bpu_pkg: ADDR_W default, INSN_BYTES=4, state enum (RUN, RECOVER), packed entry struct {pc, taken, target}.
- Sub-module bru_fifo: synchronous FIFO of entries with push, pop, flush, full, empty, count. Top holds compare logic, FSM, penalty counter and statistics.

## Test plan
- Reset mid-stream with 5 entries held → next cycle occupancy 0, all counters 0, orphan_err 0, pred_ready 1.
- Push (0x100,T,0x200),(0x104,N),(0x108,T,0x400); resolve matching outcomes → no redirect, total_branch 3, total_mispred 0, occupancy 0.
- Push (0x40,N), 2 more entries; resolve taken 0x80 → redirect_valid one cycle, redirect_pc 0x80, occupancy 0, pred_ready low 3 cycles, stall_cycles 3.
- Push (0x300,T,0x500), resolve T 0x504 → redirect 0x504; push (0x10,T,0x90), resolve N → redirect 0x14; total_mispred 2.
- Fill 8 entries → pred_ready 0, occupancy 8; correct pop with pred_valid → push refused, occupancy 7. Mispredict resolve with concurrent pred_valid → push dropped, occupancy 0.
- res_valid with FIFO empty → res_ready 0, orphan_err 1 and stays 1, total_branch unchanged.
